// File: rtl/expr_tx_pkg.sv
// Shared definitions for the ASCII expression transmitter: token codes,
// ASCII characters, FSM states and the token-to-character mapping.
package expr_tx_pkg;

  localparam int TOK_W = 5;
  // Wide enough to hold a count of 16, the largest supported buffer depth.
  localparam int CNT_W = 5;

  localparam logic [TOK_W-1:0] TOK_HEX_MAX = 5'd15;
  localparam logic [TOK_W-1:0] TOK_LPAREN  = 5'd16;
  localparam logic [TOK_W-1:0] TOK_RPAREN  = 5'd17;
  localparam logic [TOK_W-1:0] TOK_MUL     = 5'd18;
  localparam logic [TOK_W-1:0] TOK_ADD     = 5'd19;
  localparam logic [TOK_W-1:0] TOK_SUB     = 5'd20;
  localparam logic [TOK_W-1:0] TOK_MAX     = TOK_SUB;

  localparam logic [7:0] ASC_NUL     = 8'd0;
  localparam logic [7:0] ASC_ZERO    = 8'd48;
  localparam logic [7:0] ASC_LOWER_A = 8'd97;
  localparam logic [7:0] ASC_LPAREN  = 8'd40;
  localparam logic [7:0] ASC_RPAREN  = 8'd41;
  localparam logic [7:0] ASC_MUL     = 8'd42;
  localparam logic [7:0] ASC_ADD     = 8'd43;
  localparam logic [7:0] ASC_SUB     = 8'd45;
  localparam logic [7:0] ASC_EQ      = 8'd61;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TERM,
    WAIT,
    DONE
  } tx_state_t;

  function automatic logic [7:0] tok2ascii(input logic [TOK_W-1:0] code);
    logic [7:0] c;
    c = ASC_NUL;
    if (code <= 5'd9) begin
      c = ASC_ZERO + {3'b000, code};
    end else if (code <= TOK_HEX_MAX) begin
      c = ASC_LOWER_A + {3'b000, code - 5'd10};
    end else begin
      case (code)
        TOK_LPAREN: c = ASC_LPAREN;
        TOK_RPAREN: c = ASC_RPAREN;
        TOK_MUL:    c = ASC_MUL;
        TOK_ADD:    c = ASC_ADD;
        TOK_SUB:    c = ASC_SUB;
        default:    c = ASC_NUL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/expr_tok_buf.sv
// Token buffer for the transmitter. Reads do not consume entries, so the
// count stays at the number written until the whole buffer is cleared.
module expr_tok_buf
  import expr_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [TOK_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [TOK_W-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             all_read
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [TOK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full     = count == CNT_W'(DEPTH);
  assign empty    = count == '0;
  assign all_read = rd_ptr == count;
  assign do_wr    = wr_en && !full && !clr;
  assign do_rd    = rd_en && !all_read && !clr;
  assign rd_data  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/expr_ascii_tx.sv
// Transmit side of the ASCII calculator link: buffers host tokens, streams
// them as characters terminated by '=', then captures the calculator reply.
module expr_ascii_tx
  import expr_tx_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok,
  output logic       tok_ready,
  input  logic       send,
  output logic       busy,
  output logic [7:0] ascii_out,
  output logic       ready,
  input  logic       aec_valid,
  input  logic [6:0] aec_result,
  input  logic       aec_legal,
  output logic       done,
  output logic [6:0] rsp_result,
  output logic       rsp_legal,
  output logic       timeout,
  output logic       err
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  tx_state_t        state;
  tx_state_t        next_state;
  logic [WCW-1:0]   wait_cnt;
  logic             wait_expired;
  logic             tok_illegal;
  logic             send_empty;
  logic             wr_en;
  logic             rd_en;
  logic             clr;
  logic             full;
  logic             empty;
  logic             all_read;
  logic [TOK_W-1:0] rd_data;
  logic [7:0]       ascii_nxt;
  logic             ready_nxt;

  // send has priority over a same-cycle token write.
  assign tok_ready    = (state == IDLE) && !full && !send;
  assign tok_illegal  = tok > TOK_MAX;
  assign wr_en        = tok_valid && tok_ready && !tok_illegal;
  assign send_empty   = (state == IDLE) && send && empty;
  assign wait_expired = wait_cnt == WCW'(TIMEOUT - 1);
  assign clr          = state == DONE;

  expr_tok_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (tok),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .all_read(all_read)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (send && !empty) next_state = SEND;
      SEND:    if (all_read) next_state = TERM;
      TERM:    next_state = WAIT;
      WAIT:    if (aec_valid || wait_expired) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered below,
  // so each character appears in the same cycle as the state that owns it.
  always_comb begin
    ascii_nxt = ASC_NUL;
    ready_nxt = 1'b0;
    rd_en     = 1'b0;
    if (next_state == SEND) begin
      ascii_nxt = tok2ascii(rd_data);
      rd_en     = 1'b1;
      ready_nxt = state == IDLE;
    end else if (next_state == TERM) begin
      ascii_nxt = ASC_EQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_out  <= ASC_NUL;
      ready      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      rsp_result <= '0;
      rsp_legal  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      ascii_out <= ascii_nxt;
      ready     <= ready_nxt;
      busy      <= next_state != IDLE;
      done      <= (state == WAIT) && (next_state == DONE);
      err       <= (tok_valid && tok_ready && tok_illegal) || send_empty;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if ((state == IDLE) && send) begin
        timeout <= 1'b0;
      end else if ((state == WAIT) && !aec_valid && wait_expired) begin
        timeout <= 1'b1;
      end
      if ((state == WAIT) && aec_valid) begin
        rsp_result <= aec_result;
        rsp_legal  <= aec_legal;
      end
    end
  end

endmodule

// File: tb/tb_expr_ascii_tx.sv
// Randomized bench for expr_ascii_tx: a token queue and character table model
// the expected stream; the bench itself plays the calculator's responses.
module tb_expr_ascii_tx;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid;
  logic [4:0] tok;
  logic       tok_ready;
  logic       send;
  logic       busy;
  logic [7:0] ascii_out;
  logic       ready;
  logic       aec_valid;
  logic [6:0] aec_result;
  logic       aec_legal;
  logic       done;
  logic [6:0] rsp_result;
  logic       rsp_legal;
  logic       timeout;
  logic       err;

  int         tests = 0;
  int         fails = 0;
  int         tok_q[$];
  int         stim_q[$];
  logic [6:0] exp_rsp_result;
  logic       exp_rsp_legal;
  string      alphabet = "0123456789abcdef()*+-";

  expr_ascii_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_valid (tok_valid),
    .tok       (tok),
    .tok_ready (tok_ready),
    .send      (send),
    .busy      (busy),
    .ascii_out (ascii_out),
    .ready     (ready),
    .aec_valid (aec_valid),
    .aec_result(aec_result),
    .aec_legal (aec_legal),
    .done      (done),
    .rsp_result(rsp_result),
    .rsp_legal (rsp_legal),
    .timeout   (timeout),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tokens();
    logic exp_rdy;
    logic exp_err;
    foreach (stim_q[i]) begin
      tok_valid = 1'b1;
      tok       = 5'(stim_q[i]);
      #1;
      exp_rdy = tok_q.size() < DEPTH;
      tests++;
      if (tok_ready !== exp_rdy) begin
        $display("[TB] FAIL tok_ready[%0d]: got %b want %b", i, tok_ready, exp_rdy);
        fails++;
      end
      exp_err = exp_rdy && (stim_q[i] > 20);
      if (exp_rdy && stim_q[i] <= 20) tok_q.push_back(stim_q[i]);
      step();
      tests++;
      if (err !== exp_err) begin
        $display("[TB] FAIL err_after_write[%0d]: got %b want %b", i, err, exp_err);
        fails++;
      end
    end
    tok_valid = 1'b0;
    tok       = '0;
  endtask

  task automatic run_txn(input int delay, input logic [6:0] res, input logic leg, input bit collide);
    logic [7:0] exp_chars[$];
    foreach (tok_q[i]) exp_chars.push_back(alphabet[tok_q[i]]);
    exp_chars.push_back(8'd61);
    send = 1'b1;
    if (collide) begin
      tok_valid = 1'b1;
      tok       = 5'd7;
    end
    #1;
    tests++;
    if (tok_ready !== 1'b0) begin
      $display("[TB] FAIL send_priority: tok_ready got %b want 0", tok_ready);
      fails++;
    end
    step();
    send      = 1'b0;
    tok_valid = 1'b0;
    foreach (exp_chars[k]) begin
      tests++;
      if ({busy, ready, timeout, ascii_out} !== {1'b1, (k == 0), 1'b0, exp_chars[k]}) begin
        $display("[TB] FAIL char[%0d]: got busy=%b ready=%b timeout=%b ascii=%0d want 1 %b 0 %0d",
                 k, busy, ready, timeout, ascii_out, (k == 0), exp_chars[k]);
        fails++;
      end
      step();
    end
    for (int d = 0; d < delay; d++) begin
      tests++;
      if ({done, ascii_out} !== 9'd0) begin
        $display("[TB] FAIL wait_quiet: got done=%b ascii=%0d want 0 0", done, ascii_out);
        fails++;
      end
      step();
    end
    aec_valid  = 1'b1;
    aec_result = res;
    aec_legal  = leg;
    step();
    aec_valid  = 1'b0;
    aec_result = 7'($urandom);
    aec_legal  = 1'($urandom);
    exp_rsp_result = res;
    exp_rsp_legal  = leg;
    tok_q.delete();
    tests++;
    if ({done, timeout, rsp_result, rsp_legal} !== {1'b1, 1'b0, res, leg}) begin
      $display("[TB] FAIL capture: got done=%b timeout=%b result=%0d legal=%b want 1 0 %0d %b",
               done, timeout, rsp_result, rsp_legal, res, leg);
      fails++;
    end
    step();
    tests++;
    if ({done, busy, ascii_out} !== 10'd0) begin
      $display("[TB] FAIL back_to_idle: got done=%b busy=%b ascii=%0d want 0 0 0", done, busy, ascii_out);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tok_valid = 1'b0; tok = '0; send = 1'b0;
    aec_valid = 1'b0; aec_result = '0; aec_legal = 1'b0;
    repeat (3) step();
    tests++;
    if ({busy, ready, done, err, timeout, ascii_out, rsp_result, rsp_legal} !== 21'd0) begin
      $display("[TB] FAIL reset_outputs: got busy=%b ready=%b done=%b err=%b to=%b ascii=%0d res=%0d leg=%b want all 0",
               busy, ready, done, err, timeout, ascii_out, rsp_result, rsp_legal);
      fails++;
    end
    rst = 1'b0;
    step();
    tests++;
    if (tok_ready !== 1'b1) begin
      $display("[TB] FAIL reset_tok_ready: got %b want 1", tok_ready);
      fails++;
    end
    exp_rsp_result = '0;
    exp_rsp_legal  = 1'b0;
  endtask

  task automatic test_basic();
    stim_q = '{3, 19, 4, 18, 2};
    load_tokens();
    run_txn(2, 7'd11, 1'b1, 1'b1);
  endtask

  task automatic test_unbalanced();
    stim_q = '{16, 1, 19, 2};
    load_tokens();
    run_txn(0, 7'd123, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back($urandom_range(0, 20));
    stim_q.push_back(25);
    for (int i = 0; i < 7; i++) stim_q.push_back($urandom_range(0, 20));
    load_tokens();
    run_txn(3, 7'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_empty_send();
    send = 1'b1;
    step();
    send = 1'b0;
    tests++;
    if ({err, busy, ready, ascii_out} !== {1'b1, 10'd0}) begin
      $display("[TB] FAIL empty_send: got err=%b busy=%b ready=%b ascii=%0d want 1 0 0 0", err, busy, ready, ascii_out);
      fails++;
    end
    step();
    tests++;
    if ({err, busy, ascii_out} !== 10'd0) begin
      $display("[TB] FAIL empty_send_after: got err=%b busy=%b ascii=%0d want 0 0 0", err, busy, ascii_out);
      fails++;
    end
  endtask

  task automatic test_ignore_valid();
    for (int i = 0; i < 3; i++) begin
      aec_valid  = 1'b1;
      aec_result = 7'($urandom);
      aec_legal  = 1'($urandom);
      step();
    end
    aec_valid = 1'b0;
    step();
    tests++;
    if ({done, busy, rsp_result, rsp_legal} !== {2'b00, exp_rsp_result, exp_rsp_legal}) begin
      $display("[TB] FAIL ignore_valid: got done=%b busy=%b result=%0d legal=%b want 0 0 %0d %b",
               done, busy, rsp_result, rsp_legal, exp_rsp_result, exp_rsp_legal);
      fails++;
    end
  endtask

  task automatic test_timeout();
    int waited;
    stim_q = '{5, 19, 6};
    load_tokens();
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (tok_q.size() + 1) step();
    waited = 0;
    while (done !== 1'b1 && waited < TIMEOUT + 10) begin
      aec_result = 7'($urandom);
      step();
      waited++;
    end
    tests++;
    if (waited < TIMEOUT || waited > TIMEOUT + 1) begin
      $display("[TB] FAIL timeout_latency: got %0d cycles want %0d..%0d", waited, TIMEOUT, TIMEOUT + 1);
      fails++;
    end
    tests++;
    if ({done, timeout, rsp_result, rsp_legal} !== {2'b11, exp_rsp_result, exp_rsp_legal}) begin
      $display("[TB] FAIL timeout_flags: got done=%b timeout=%b result=%0d legal=%b want 1 1 %0d %b",
               done, timeout, rsp_result, rsp_legal, exp_rsp_result, exp_rsp_legal);
      fails++;
    end
    tok_q.delete();
    step();
    tests++;
    if ({done, timeout, busy} !== 3'b010) begin
      $display("[TB] FAIL timeout_hold: got done=%b timeout=%b busy=%b want 0 1 0", done, timeout, busy);
      fails++;
    end
    stim_q = '{9, 20, 1};
    load_tokens();
    run_txn(1, 7'd8, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    stim_q = '{1, 2, 3, 4};
    load_tokens();
    send = 1'b1;
    step();
    send = 1'b0;
    step();
    rst = 1'b1;
    step();
    tests++;
    if ({busy, ready, done, timeout, ascii_out, rsp_result, rsp_legal, tok_ready} !== 21'd1) begin
      $display("[TB] FAIL reset_mid: got busy=%b ready=%b done=%b to=%b ascii=%0d res=%0d leg=%b tok_ready=%b want 0s with tok_ready 1",
               busy, ready, done, timeout, ascii_out, rsp_result, rsp_legal, tok_ready);
      fails++;
    end
    rst = 1'b0;
    tok_q.delete();
    exp_rsp_result = '0;
    exp_rsp_legal  = 1'b0;
    step();
    stim_q = '{16, 10, 18, 15, 17};
    load_tokens();
    run_txn(4, 7'd99, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      stim_q.delete();
      for (int i = 0; i < 6; i++) stim_q.push_back($urandom_range(0, 20));
      load_tokens();
      run_txn(0, 7'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 16);
      stim_q.delete();
      stim_q.push_back($urandom_range(0, 20));
      for (int i = 1; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) stim_q.push_back($urandom_range(21, 31));
        else stim_q.push_back($urandom_range(0, 20));
      end
      load_tokens();
      run_txn($urandom_range(0, 8), 7'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unbalanced();
    test_full();
    test_empty_send();
    test_ignore_valid();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expr_ascii_tx.md
# expr_ascii_tx

Transmit side of the ASCII expression-calculator link. It buffers up to DEPTH expression tokens written by a host and serializes them as ASCII characters, one per cycle, onto the calculator's `ascii_in`/`ready` input, terminated by `'='`. It then waits for the calculator's `valid`/`result`/`parenthesesLegal` response, captures it, and returns it to the host. It sits between host control logic (or a testbench sequencer) and the calculator core.

## Interface

Parameters:
- DEPTH, 16 — token buffer capacity. Max 16: the calculator holds 16 characters excluding `'='`.
- TIMEOUT, 255 — maximum WAIT cycles before the response is abandoned.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tok_valid  in  1  host token write strobe.
- tok  in  5  token code: 0–15 hex digit, 16 `(`, 17 `)`, 18 `*`, 19 `+`, 20 `-`.
- tok_ready  out  1  token accepted when `tok_valid & tok_ready`.
- send  in  1  start transmission (sampled in IDLE only).
- busy  out  1  high in every state except IDLE.
- ascii_out  out  8  character to the calculator's `ascii_in`.
- ready  out  1  first-character strobe to the calculator.
- aec_valid  in  1  calculator response strobe.
- aec_result  in  7  calculator result.
- aec_legal  in  1  calculator `parenthesesLegal`.
- done  out  1  one-cycle pulse when the response is captured or times out.
- rsp_result  out  7  captured result.
- rsp_legal  out  1  captured legality.
- timeout  out  1  set with `done` when no response arrived; cleared on next `send`.
- err  out  1  one-cycle pulse for an illegal token code (≥21, dropped) or `send` with an empty buffer.

## Operation

- Reset values: state IDLE, count/wr/rd pointers 0, `ascii_out`=0x00, and `ready`, `done`, `err`, `timeout`, `rsp_result`, `rsp_legal`, `busy` all 0. Buffer contents are don't-care.
- `tok_ready` = IDLE & count<DEPTH & !send. This is combinational on `send`, so `send` wins over a same-cycle write and that token is not taken.
- Illegal codes are handshaken (consumed) but not stored; `err` pulses the next cycle.
- Character mapping: 0–9 → 48–57; 10–15 → 97–102 (lowercase a–f); `(` 40, `)` 41, `*` 42, `+` 43, `-` 45. The terminator is 61.
- States:
  - IDLE → SEND on `send` & count>0.
  - `send` & count==0 stays in IDLE and pulses `err`.
  - SEND: emits buf[rd], rd++; → TERM after the char at index count-1.
  - TERM: emits 61; → WAIT.
  - WAIT: `ascii_out`=0x00; wait counter++. → DONE on `aec_valid`, capturing `aec_result`/`aec_legal`. → DONE with `timeout`=1 when the counter reaches TIMEOUT.
  - DONE: `done`=1; count, wr and rd cleared; → IDLE.
- `ready`=1 only in the first SEND cycle. `ascii_out` is 0x00 whenever not in SEND or TERM. It must never idle at 61, because the calculator treats 61 as the terminator.
- `rsp_*` hold their values until the next capture. They are not modified on timeout.
- `aec_valid` outside WAIT is ignored.
- `rst` mid-operation (any state) returns everything to reset values immediately. The calculator must be reset alongside it.

## Timing

- `send` high in cycle t: first character and `ready` appear at t+1; character k at t+1+k; `'='` at t+1+N.
- Outputs are registered; `ascii_out` changes only on a clock edge.
- `aec_valid` seen in cycle v: `done` and `rsp_*` are valid at v+1; IDLE at v+2. The earliest next `ready` is v+3, which guarantees the calculator has passed its RESET state back to BUFFER.
- Back-to-back token writes are accepted at 1 per cycle.

## Structure

- Package `expr_tx_pkg` holds:
  - token code constants;
  - ASCII constants (`ASC_LPAREN`, `ASC_EQ`, …);
  - state enum (IDLE, SEND, TERM, WAIT, DONE);
  - a `tok2ascii` function.
- Sub-module `expr_tok_buf` is a DEPTH×5 register buffer with write pointer, read pointer, count and full/empty flags, plus a clear input driven in DONE. The FSM, wait counter and response capture stay in the top module.

## Test plan

- Load tokens 3,19,4,18,2 ("3+4*2") then `send` → `ascii_out` 51,43,52,42,50,61 on consecutive cycles, `ready` only with 51; calculator model returns 11 → `done` pulse, `rsp_result`=11, `rsp_legal`=1.
- Load `(`,1,19,2 ("(1+2"), `send` → model returns 123 with legal=0 → `rsp_result`=123, `rsp_legal`=0.
- Write 17 tokens → `tok_ready` drops after the 16th; the 17th is held off. `send` → 16 chars then 61. Write code 25 → `err` pulse, count unchanged.
- `send` with an empty buffer → `err` pulse, `busy` stays 0, `ascii_out` stays 0x00.
- `aec_valid` withheld for TIMEOUT cycles → `done` with `timeout`=1 and `rsp_*` unchanged. The next `send` clears `timeout`.
- Assert `rst` during SEND after 2 chars → next edge: IDLE, `ascii_out`=0x00, `ready`=0; a subsequent full transaction completes correctly.
